// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scan controller: register map,
// STATUS bit layout, scan FSM encoding and event field widths.
package keypad_pkg;

  localparam logic [1:0] KP_STATUS = 2'd0;
  localparam logic [1:0] KP_EVENT  = 2'd1;
  localparam logic [1:0] KP_CTRL   = 2'd2;
  localparam logic [1:0] KP_KEYS   = 2'd3;

  localparam int ST_COUNT_LSB  = 0;
  localparam int ST_COUNT_MSB  = 4;
  localparam int ST_EMPTY_BIT  = 5;
  localparam int ST_OVF_BIT    = 6;
  localparam int ST_IRQEN_BIT  = 7;
  localparam int ST_ENABLE_BIT = 8;

  localparam int NUM_KEYS = 16;
  localparam int EV_IDX_W = 4;
  localparam int EV_W     = EV_IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN0  = 3'd1,
    S_SCAN1  = 3'd2,
    S_SCAN2  = 3'd3,
    S_SCAN3  = 3'd4,
    S_UPDATE = 3'd5,
    S_EMIT   = 3'd6
  } scan_state_t;

  // Column drive pattern for a state: one column pulled low while scanning.
  function automatic logic [3:0] col_drive(input scan_state_t st);
    case (st)
      S_SCAN0: return 4'b1110;
      S_SCAN1: return 4'b1101;
      S_SCAN2: return 4'b1011;
      S_SCAN3: return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// Small synchronous event FIFO. A push into a full FIFO is dropped unless a
// pop happens in the same cycle; dropped pushes are flagged for one cycle.
module kp_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (count_r == {(AW+1){1'b0}});
  assign full      = (count_r == CNT_FULL);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign dropped   = push & full & ~do_pop_s;
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers (wrap naturally at power-of-two depth) and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column scan at a programmable tick rate, per-key
// frame debounce, press/release events queued for the CPU, level irq.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int CLK_DIV    = 100,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  keypad_row,
  output logic [3:0]  keypad_col,
  input  logic        reg_en,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        irq,
  output logic [15:0] keypad
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [3:0]    DB_MAX   = 4'(DEBOUNCE);
  localparam int FAW = $clog2(FIFO_DEPTH);

  scan_state_t state_r, state_s;
  logic [TW-1:0]               tick_cnt_r;
  logic                        tick_s;
  logic [3:0]                  idx_r;
  logic [NUM_KEYS-1:0]         raw_r, kp_r, changed_r;
  logic [NUM_KEYS-1:0]         kp_upd_s, chg_upd_s;
  logic [NUM_KEYS-1:0][3:0]    dbc_r, dbc_upd_s;
  logic                        scanning_s;
  logic [1:0]                  scan_col_s;
  logic                        enable_r, irq_en_r, ovf_r, irq_r;
  logic [3:0]                  col_r;
  logic                        wr_ctrl_s, pop_s, push_s;
  logic [EV_W-1:0]             head_s;
  logic                        fifo_full_s, fifo_empty_s, fifo_drop_s;
  logic [FAW:0]                fifo_count_s;
  logic                        unused_s;

  assign unused_s  = ^reg_wdata[31:3] ^ fifo_full_s;
  assign tick_s    = (tick_cnt_r == TICK_MAX);
  assign wr_ctrl_s = reg_en & reg_we & (reg_addr == KP_CTRL);
  assign pop_s     = reg_en & ~reg_we & (reg_addr == KP_EVENT);
  assign push_s    = (state_r == S_EMIT) & changed_r[idx_r];

  assign keypad_col = col_r;
  assign keypad     = kp_r;
  assign irq        = irq_r;

  // Free-running scan tick divider; held at zero while scanning is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (!enable_r || tick_s) begin
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_ONE;
    end
  end

  // Current scan column decoded from the FSM state.
  always_comb begin
    scanning_s = 1'b1;
    case (state_r)
      S_SCAN0: scan_col_s = 2'd0;
      S_SCAN1: scan_col_s = 2'd1;
      S_SCAN2: scan_col_s = 2'd2;
      S_SCAN3: scan_col_s = 2'd3;
      default: begin
        scan_col_s = 2'd0;
        scanning_s = 1'b0;
      end
    endcase
  end

  // Next-state logic: a disable aborts a scan immediately but lets EMIT finish.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:   if (enable_r) state_s = S_SCAN0; else state_s = S_IDLE;
      S_SCAN0:  if (!enable_r) state_s = S_IDLE; else if (tick_s) state_s = S_SCAN1; else state_s = S_SCAN0;
      S_SCAN1:  if (!enable_r) state_s = S_IDLE; else if (tick_s) state_s = S_SCAN2; else state_s = S_SCAN1;
      S_SCAN2:  if (!enable_r) state_s = S_IDLE; else if (tick_s) state_s = S_SCAN3; else state_s = S_SCAN2;
      S_SCAN3:  if (!enable_r) state_s = S_IDLE; else if (tick_s) state_s = S_UPDATE; else state_s = S_SCAN3;
      S_UPDATE: state_s = S_EMIT;
      S_EMIT: begin
        if (idx_r != 4'd15) state_s = S_EMIT;
        else if (enable_r)  state_s = S_SCAN0;
        else                state_s = S_IDLE;
      end
      default:  state_s = S_IDLE;
    endcase
  end

  // Per-key debounce step applied once per frame in UPDATE.
  always_comb begin
    kp_upd_s  = kp_r;
    chg_upd_s = changed_r;
    dbc_upd_s = dbc_r;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (raw_r[k] == kp_r[k]) begin
        dbc_upd_s[k] = 4'd0;
      end else if ((dbc_r[k] + 4'd1) == DB_MAX) begin
        kp_upd_s[k]  = ~kp_r[k];
        chg_upd_s[k] = 1'b1;
        dbc_upd_s[k] = 4'd0;
      end else begin
        dbc_upd_s[k] = dbc_r[k] + 4'd1;
      end
    end
  end

  // FSM state, column drive, raw capture, debounce state and emit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      col_r     <= 4'b1111;
      idx_r     <= 4'd0;
      raw_r     <= {NUM_KEYS{1'b0}};
      kp_r      <= {NUM_KEYS{1'b0}};
      changed_r <= {NUM_KEYS{1'b0}};
      dbc_r     <= '{default: 4'd0};
    end else begin
      state_r <= state_s;
      col_r   <= col_drive(state_s);
      if (state_r == S_IDLE) begin
        raw_r <= {NUM_KEYS{1'b0}};
      end else if (scanning_s && enable_r && tick_s) begin
        raw_r[{scan_col_s, 2'b00} +: 4] <= ~keypad_row;
      end
      if (state_r == S_UPDATE) begin
        kp_r      <= kp_upd_s;
        changed_r <= chg_upd_s;
        dbc_r     <= dbc_upd_s;
        idx_r     <= 4'd0;
      end else if (state_r == S_EMIT) begin
        changed_r[idx_r] <= 1'b0;
        idx_r            <= idx_r + 4'd1;
      end
    end
  end

  // Control register, sticky overflow (set beats clear) and registered irq.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_r <= 1'b1;
      irq_en_r <= 1'b0;
      ovf_r    <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        enable_r <= reg_wdata[0];
        irq_en_r <= reg_wdata[1];
      end
      if (fifo_drop_s) begin
        ovf_r <= 1'b1;
      end else if (wr_ctrl_s && reg_wdata[2]) begin
        ovf_r <= 1'b0;
      end
      irq_r <= irq_en_r & ~fifo_empty_s;
    end
  end

  kp_event_fifo #(.DEPTH(FIFO_DEPTH), .W(EV_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data ({kp_r[idx_r], idx_r}),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s),
    .dropped   (fifo_drop_s)
  );

  // Register read mux.
  always_comb begin
    reg_rdata = 32'd0;
    case (reg_addr)
      KP_STATUS: begin
        reg_rdata[ST_COUNT_MSB:ST_COUNT_LSB] = 5'(fifo_count_s);
        reg_rdata[ST_EMPTY_BIT]  = fifo_empty_s;
        reg_rdata[ST_OVF_BIT]    = ovf_r;
        reg_rdata[ST_IRQEN_BIT]  = irq_en_r;
        reg_rdata[ST_ENABLE_BIT] = enable_r;
      end
      KP_EVENT: begin
        if (!fifo_empty_s) reg_rdata = {1'b1, 26'd0, head_s};
        else               reg_rdata = 32'd0;
      end
      KP_CTRL:  reg_rdata = {30'd0, irq_en_r, enable_r};
      KP_KEYS:  reg_rdata = {16'd0, kp_r};
      default:  reg_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model drives the rows, directed
// key patterns queue expected events, and a monitor checks every EVENT read.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  keypad_row;
  logic [3:0]  keypad_col;
  logic        reg_en = 1'b0;
  logic        reg_we = 1'b0;
  logic [1:0]  reg_addr = KP_STATUS;
  logic [31:0] reg_wdata = 32'd0;
  logic [31:0] reg_rdata;
  logic        irq;
  logic [15:0] keypad;

  logic [15:0] keys_held = 16'd0;
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  keypad_scan_ctrl #(.CLK_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .keypad_row (keypad_row),
    .keypad_col (keypad_col),
    .reg_en     (reg_en),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .irq        (irq),
    .keypad     (keypad)
  );

  always #5 clk = ~clk;

  // Matrix model: a held key pulls its row low while its column is driven.
  always_comb begin
    keypad_row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!keypad_col[c] && keys_held[c*4+r]) keypad_row[r] = 1'b0;
  end

  // Monitor: every valid EVENT read must match the oldest expected event.
  always @(negedge clk) begin
    logic [31:0] ev;
    if (rst && reg_en && !reg_we && reg_addr == KP_EVENT && reg_rdata[31]) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL event_unexpected: got %h, none expected", reg_rdata);
      end else begin
        ev = exp_q.pop_front();
        if (reg_rdata !== ev) begin
          n_err++;
          $display("FAIL event_data: got %h expected %h", reg_rdata, ev);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    @(posedge clk); #1;
    reg_en = 1'b1; reg_we = we; reg_addr = addr; reg_wdata = wd;
    @(negedge clk);
    rd = reg_rdata;
    @(posedge clk); #1;
    reg_en = 1'b0; reg_we = 1'b0; reg_addr = KP_STATUS; reg_wdata = 32'd0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the first negedge of the n-th UPDATE (column drive 0111 -> 1111).
  task automatic wait_frames(input int n);
    logic [3:0] last;
    int got;
    int budget;
    got = 0;
    budget = n * 200;
    last = keypad_col;
    while (got < n && budget > 0) begin
      @(negedge clk);
      if (last == 4'b0111 && keypad_col == 4'b1111) got++;
      last = keypad_col;
      budget--;
    end
    if (got < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", got, n);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        ok;
    int          budget;

    // Reset values
    wait_clks(3);
    chk("rst_col", {28'd0, keypad_col}, 32'h0000_000F);
    chk("rst_keypad", {16'd0, keypad}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_status", reg_rdata, 32'h0000_0120);
    rst = 1'b1;

    // Press key 6: debounced after the second frame, one event
    wait_frames(1);
    keys_held = 16'h0040;
    exp_q.push_back(32'h8000_0016);
    wait_frames(1); wait_clks(1);
    chk("press_frame1", {16'd0, keypad}, 32'h0000_0000);
    wait_frames(1); wait_clks(1);
    chk("press_frame2", {16'd0, keypad}, 32'h0000_0040);
    wait_clks(20);
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    wait_frames(1); wait_clks(1);
    chk("press_frame3", {16'd0, keypad}, 32'h0000_0040);
    bus(1'b0, KP_STATUS, 32'd0, rd);
    chk("status_one", rd, 32'h0000_0101);
    bus(1'b1, KP_CTRL, 32'h0000_0003, rd);
    wait_clks(2);
    chk("irq_enabled", {31'd0, irq}, 32'd1);
    bus(1'b0, KP_EVENT, 32'd0, rd);
    wait_clks(2);
    chk("irq_after_pop", {31'd0, irq}, 32'd0);

    // Release with a one-frame bounce, then a steady release
    wait_frames(1);
    keys_held = 16'h0000;
    wait_frames(1);
    keys_held = 16'h0040;
    wait_frames(1);
    keys_held = 16'h0000;
    exp_q.push_back(32'h8000_0006);
    wait_frames(1); wait_clks(1);
    chk("bounce_kept", {16'd0, keypad}, 32'h0000_0040);
    bus(1'b0, KP_STATUS, 32'd0, rd);
    chk("bounce_no_event", rd, 32'h0000_01A0);
    wait_frames(1); wait_clks(1);
    chk("release_keypad", {16'd0, keypad}, 32'h0000_0000);
    wait_clks(20);
    bus(1'b0, KP_EVENT, 32'd0, rd);

    // Keys 0 and 15 in the same frame: events in index order
    wait_frames(1);
    keys_held = 16'h8001;
    exp_q.push_back(32'h8000_0010);
    exp_q.push_back(32'h8000_001F);
    wait_frames(2); wait_clks(20);
    bus(1'b0, KP_STATUS, 32'd0, rd);
    chk("two_events_status", rd, 32'h0000_0182);
    chk("two_keys_keypad", {16'd0, keypad}, 32'h0000_8001);
    bus(1'b0, KP_EVENT, 32'd0, rd);
    bus(1'b0, KP_EVENT, 32'd0, rd);

    // Ten transitions into an 8-deep FIFO: oldest 8 kept, overflow sticky
    wait_frames(1);
    keys_held = 16'h001E;
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h8000_0011);
    exp_q.push_back(32'h8000_0012);
    exp_q.push_back(32'h8000_0013);
    exp_q.push_back(32'h8000_0014);
    exp_q.push_back(32'h8000_000F);
    wait_frames(2);
    keys_held = 16'h0000;
    exp_q.push_back(32'h8000_0001);
    exp_q.push_back(32'h8000_0002);
    wait_frames(2); wait_clks(20);
    bus(1'b0, KP_STATUS, 32'd0, rd);
    chk("overflow_status", rd, 32'h0000_01C8);
    bus(1'b1, KP_CTRL, 32'h0000_0007, rd);
    bus(1'b0, KP_STATUS, 32'd0, rd);
    chk("overflow_cleared", rd, 32'h0000_0188);
    for (int i = 0; i < 8; i++) bus(1'b0, KP_EVENT, 32'd0, rd);
    bus(1'b0, KP_STATUS, 32'd0, rd);
    chk("drained_status", rd, 32'h0000_01A0);
    bus(1'b0, KP_EVENT, 32'd0, rd);
    chk("empty_event_read", rd, 32'd0);
    chk("drained_irq", {31'd0, irq}, 32'd0);

    // Disable while SCAN2 is driving, then re-enable
    budget = 200;
    while (keypad_col != 4'b1011 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("reach_scan2", {28'd0, keypad_col}, 32'h0000_000B);
    bus(1'b1, KP_CTRL, 32'd0, rd);
    wait_clks(2);
    chk("disable_col", {28'd0, keypad_col}, 32'h0000_000F);
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (keypad_col != 4'b1111) ok = 1'b0;
    end
    chk("disabled_hold", {31'd0, ok}, 32'd1);
    bus(1'b0, KP_STATUS, 32'd0, rd);
    chk("disabled_status", rd, 32'h0000_0020);
    bus(1'b1, KP_CTRL, 32'h0000_0003, rd);
    budget = 10;
    while (keypad_col == 4'b1111 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("restart_scan0", {28'd0, keypad_col}, 32'h0000_000E);

    // Reset while EMIT is pushing
    wait_frames(1);
    keys_held = 16'hFFFF;
    wait_frames(2); wait_clks(4);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_keypad", {16'd0, keypad}, 32'd0);
    chk("async_rst_col", {28'd0, keypad_col}, 32'h0000_000F);
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    chk("async_rst_status", reg_rdata, 32'h0000_0120);
    keys_held = 16'h0000;
    wait_clks(3);
    rst = 1'b1;
    bus(1'b0, KP_EVENT, 32'd0, rd);
    chk("post_rst_event", rd, 32'd0);
    bus(1'b0, KP_STATUS, 32'd0, rd);
    chk("post_rst_status", rd, 32'h0000_0120);

    chk("events_left", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
